nand_target_emu: RTL and testbench
==================================

// Module: nand_target_emu
// PURPOSE
//  Synthesizable NAND flash target that answers the NAND pin interface (nCE/CLE/ALE/nWE/nRE/nWP/IO).
//  It decodes commands, addresses and data the way a small x8 NAND device would.
//  It is the device-side counterpart of the APB NAND controller, for on-chip loopback and bring-up.
//  No external flash is needed.
// PARAMETERS
//  PAGE_BYTES  64    bytes per page (power of 2, <=256)
//  NUM_PAGES   16    pages in array (power of 2, <=256)
//  TBUSY_PROG  80    PCLK cycles RnB low after 0x10 (must be >= PAGE_BYTES)
//  TBUSY_READ  8     PCLK cycles RnB low after 0x30
//  TBUSY_RST   4     PCLK cycles RnB low after 0xFF
//  ID0         8'hEC first Read-ID byte
//  ID1         8'hDA second Read-ID byte
// PORTS
//  PCLK     in   1  system clock; all logic on rising edge
//  PRESETN  in   1  asynchronous active-low reset
//  nCE      in   1  chip enable, active low
//  CLE      in   1  command latch enable
//  ALE      in   1  address latch enable
//  nWE      in   1  write strobe; latch on rising edge
//  nRE      in   1  read strobe; advance on falling edge
//  nWP      in   1  write protect, active low
//  IO_in    in   8  IO bus from controller
//  IO_out   out  8  IO bus toward controller
//  IO_oe    out  1  drive enable for IO_out
//  RnB      out  1  ready(1)/busy(0)
// BEHAVIOUR
//  Reset values:
//   - RnB=1, IO_out=0, IO_oe=0, state=IDLE, fail=0, col=0, row=0, addr_cnt=0.
//   - Array RAM and page buffer are not cleared.
//  Sampling:
//   - nWE and nRE pass through 2-FF synchronizers; edges are detected on the synced copies.
//   - CLE, ALE and IO_in are sampled at the detected nWE rise, so the controller holds them >=3 PCLK.
//   - When nCE=1, all strobes are ignored and IO_oe=0; state is retained.
//  nWE rise with nCE=0:
//   - CLE=1, ALE=0: command. CLE=1, ALE=1: ignored.
//   - CLE=0, ALE=1: address byte. addr_cnt 0->col[7:0], 1->col[15:8], 2->row; bytes 3+ ignored.
//   - Index into array = row mod NUM_PAGES, col mod PAGE_BYTES.
//   - CLE=0, ALE=0 in PROG_DATA: buf[col]<=IO_in, col++ (wraps at PAGE_BYTES). Data in any other state is ignored.
//  Commands (any new command clears addr_cnt):
//   - 0x00: ->READ_ADDR, col=0.
//   - 0x30 in READ_ADDR: RnB=0 for TBUSY_READ, then ->READ_OUT.
//   - 0x80: ->PROG_ADDR, col=0, page buffer filled with 0xFF. The first data byte moves PROG_ADDR->PROG_DATA.
//   - 0x10 in PROG_DATA: RnB=0 for TBUSY_PROG.
//     - nWP=1: buf copied to array page, 1 byte/cycle over the first PAGE_BYTES busy cycles; fail=0.
//     - nWP=0: array unchanged, fail=1.
//     - Then ->IDLE.
//   - 0x90: ->ID_OUT. 0x70: ->STATUS_OUT (previous state saved).
//   - 0xFF: abort anything (including an in-progress copy; bytes already copied stay written).
//     RnB=0 for TBUSY_RST, fail=0, ->IDLE.
//   - Unknown opcode: ->IDLE.
//   - While RnB=0 only 0x70 and 0xFF are accepted; all else is ignored.
//  Status byte = {nWP, RnB, 5'b0, fail}.
//   - A 0x00 issued while in STATUS_OUT returns to the saved READ_OUT without reloading col.
//  Output:
//   - IO_oe=1 iff nCE=0, synced nRE=0, state in {READ_OUT, ID_OUT, STATUS_OUT}.
//   - At each synced nRE fall, IO_out is registered 1 PCLK later; total 3 PCLK from pin edge.
//   - READ_OUT: IO_out=array[row][col], then col++ (wraps).
//   - ID_OUT: ID0, ID1, then 0x00 repeated.
//   - STATUS_OUT: status byte on every read, live.
//  Simultaneous events:
//   - nWE rise and nRE fall in the same cycle: the nWE event wins and the nRE edge is dropped.
// TESTING
//  T1 reset, then cmd 0x90 and two nRE pulses -> IO_out=0xEC then 0xDA, IO_oe only while nRE low; 3rd pulse -> 0x00.
//  T2 0x80, addr 00,00,03, data 11,22,33, 0x10 (nWP=1) -> RnB low exactly 80 cycles.
//     Then 0x00, addr 00,00,03, 0x30 -> after 8 busy cycles reads 11,22,33,FF.
//  T3 same program with nWP=0 -> 0x70 returns 0x41 (bit7=0, bit6=1, bit0=1); page 3 unchanged on readback.
//  T4 0x70 during program busy -> 0x00 (RnB=0, nWP=0 -> bits 7,6 low); with nWP=1 -> 0x80. 0x00 sent while busy is ignored.
//  T5 0xFF mid-program busy -> RnB low 4 cycles then high, state IDLE; assert PRESETN mid-read -> RnB=1, IO_oe=0 same cycle.
//  T6 read with col=PAGE_BYTES-1, 2 nRE pulses -> last byte then byte 0 (wrap); nCE=1 strobes -> no IO_oe, no col change.

Source files
------------

// File: rtl/nand_target_emu_if.sv
`default_nettype none
// ============================================================================
// Module   : nand_target_emu_if
// Purpose  : Pin bundle of an x8 NAND device (controller <-> target).
// Revision : 1.0 - initial release
// ============================================================================
interface nand_target_emu_if;
  logic       nCE;
  logic       CLE;
  logic       ALE;
  logic       nWE;
  logic       nRE;
  logic       nWP;
  logic [7:0] IO_in;
  logic [7:0] IO_out;
  logic       IO_oe;
  logic       RnB;

  modport master (output nCE, CLE, ALE, nWE, nRE, nWP, IO_in,
                  input  IO_out, IO_oe, RnB);
  modport slave  (input  nCE, CLE, ALE, nWE, nRE, nWP, IO_in,
                  output IO_out, IO_oe, RnB);
endinterface
`default_nettype wire

// File: rtl/nand_target_emu.sv
`default_nettype none
// ============================================================================
// Module   : nand_target_emu
// Purpose  : Small x8 NAND flash target answering the NAND pin protocol.
// Revision : 1.0 - initial release
// ============================================================================
module nand_target_emu #(
  parameter int         PAGE_BYTES = 64,
  parameter int         NUM_PAGES  = 16,
  parameter int         TBUSY_PROG = 80,
  parameter int         TBUSY_READ = 8,
  parameter int         TBUSY_RST  = 4,
  parameter logic [7:0] ID0        = 8'hEC,
  parameter logic [7:0] ID1        = 8'hDA
) (
  input  logic             PCLK,
  input  logic             PRESETN,
  nand_target_emu_if.slave nif
);
  localparam int c_col_w = $clog2(PAGE_BYTES);
  localparam int c_row_w = $clog2(NUM_PAGES);

  typedef enum logic [2:0] {
    ST_IDLE, ST_READ_ADDR, ST_READ_OUT, ST_PROG_ADDR,
    ST_PROG_DATA, ST_ID_OUT, ST_STATUS_OUT
  } state_t;
  typedef enum logic [1:0] {BK_NONE, BK_READ, BK_PROG, BK_RST} busy_t;

  state_t               r_state, w_state_nxt, r_saved, w_saved_nxt;
  busy_t                r_busy_kind, w_busy_kind_nxt;
  logic [15:0]          r_col, w_col_nxt, r_busy_cnt, w_busy_cnt_nxt;
  logic [7:0]           r_row, w_row_nxt, r_io_out, w_io_out_nxt;
  logic [1:0]           r_addr_cnt, w_addr_cnt_nxt, r_id_idx, w_id_idx_nxt;
  logic                 r_fail, w_fail_nxt, r_copy_on, w_copy_on_nxt;
  logic [c_col_w-1:0]   r_copy_idx, w_copy_idx_nxt, w_col_idx, w_col_inc;
  logic [c_row_w-1:0]   w_row_idx;
  logic                 r_nwe_s1, r_nwe_s2, r_nwe_d, r_nre_s1, r_nre_s2, r_nre_d;
  logic                 w_we_rise, w_re_fall, w_busy, w_rnb;
  logic                 w_buf_fill, w_buf_we, w_mem_we;
  logic [7:0]           w_mem_rd, w_status;
  logic [7:0]           r_buf [0:PAGE_BYTES-1];
  logic [7:0]           r_mem [0:NUM_PAGES*PAGE_BYTES-1];

  assign w_col_idx = r_col[c_col_w-1:0];
  assign w_col_inc = w_col_idx + 1'b1;
  assign w_row_idx = r_row[c_row_w-1:0];
  assign w_mem_rd  = r_mem[{w_row_idx, w_col_idx}];
  assign w_busy    = (r_busy_cnt != 16'd0);
  assign w_rnb     = ~w_busy;
  assign w_status  = {nif.nWP, w_rnb, 5'b0, r_fail};
  // A same-cycle nWE rise takes priority and swallows the nRE edge
  assign w_we_rise = r_nwe_s2 & ~r_nwe_d & ~nif.nCE;
  assign w_re_fall = ~r_nre_s2 & r_nre_d & ~nif.nCE & ~w_we_rise;

  assign nif.RnB    = w_rnb;
  assign nif.IO_out = r_io_out;
  assign nif.IO_oe  = ~nif.nCE & ~r_nre_s2 &
                      (r_state == ST_READ_OUT || r_state == ST_ID_OUT ||
                       r_state == ST_STATUS_OUT);

  always_comb begin
    w_state_nxt     = r_state;
    w_saved_nxt     = r_saved;
    w_busy_kind_nxt = r_busy_kind;
    w_col_nxt       = r_col;
    w_busy_cnt_nxt  = r_busy_cnt;
    w_row_nxt       = r_row;
    w_io_out_nxt    = r_io_out;
    w_addr_cnt_nxt  = r_addr_cnt;
    w_id_idx_nxt    = r_id_idx;
    w_fail_nxt      = r_fail;
    w_copy_on_nxt   = r_copy_on;
    w_copy_idx_nxt  = r_copy_idx;
    w_buf_fill      = 1'b0;
    w_buf_we        = 1'b0;
    w_mem_we        = 1'b0;

    if (w_busy) begin
      w_busy_cnt_nxt = r_busy_cnt - 16'd1;
      // Read busy ends: land in READ_OUT, or behind a pending status read
      if (r_busy_cnt == 16'd1 && r_busy_kind == BK_READ) begin
        if (r_state == ST_STATUS_OUT) w_saved_nxt = ST_READ_OUT;
        else                          w_state_nxt = ST_READ_OUT;
      end
    end
    if (r_copy_on) begin
      w_mem_we       = 1'b1;
      w_copy_idx_nxt = r_copy_idx + 1'b1;
      if (r_copy_idx == c_col_w'(PAGE_BYTES - 1)) w_copy_on_nxt = 1'b0;
    end

    if (w_we_rise) begin
      if (nif.CLE && !nif.ALE) begin
        if (nif.IO_in == 8'hFF) begin
          w_addr_cnt_nxt  = 2'd0;
          w_busy_cnt_nxt  = 16'(TBUSY_RST);
          w_busy_kind_nxt = BK_RST;
          w_fail_nxt      = 1'b0;
          w_copy_on_nxt   = 1'b0;
          w_state_nxt     = ST_IDLE;
        end else if (nif.IO_in == 8'h70) begin
          w_addr_cnt_nxt = 2'd0;
          if (w_state_nxt != ST_STATUS_OUT) w_saved_nxt = w_state_nxt;
          w_state_nxt = ST_STATUS_OUT;
        end else if (!w_busy) begin
          w_addr_cnt_nxt = 2'd0;
          case (nif.IO_in)
            8'h00: begin
              if (r_state == ST_STATUS_OUT && r_saved == ST_READ_OUT) begin
                w_state_nxt = ST_READ_OUT;
              end else begin
                w_state_nxt = ST_READ_ADDR;
                w_col_nxt   = 16'd0;
              end
            end
            8'h30: begin
              if (r_state == ST_READ_ADDR) begin
                w_busy_cnt_nxt  = 16'(TBUSY_READ);
                w_busy_kind_nxt = BK_READ;
              end else begin
                w_state_nxt = ST_IDLE;
              end
            end
            8'h80: begin
              w_state_nxt = ST_PROG_ADDR;
              w_col_nxt   = 16'd0;
              w_buf_fill  = 1'b1;
            end
            8'h10: begin
              if (r_state == ST_PROG_DATA) begin
                w_busy_cnt_nxt  = 16'(TBUSY_PROG);
                w_busy_kind_nxt = BK_PROG;
                w_fail_nxt      = ~nif.nWP;
                w_copy_on_nxt   = nif.nWP;
                w_copy_idx_nxt  = '0;
              end
              w_state_nxt = ST_IDLE;
            end
            8'h90: begin
              w_state_nxt  = ST_ID_OUT;
              w_id_idx_nxt = 2'd0;
            end
            default: w_state_nxt = ST_IDLE;
          endcase
        end
      end else if (!nif.CLE && nif.ALE && !w_busy) begin
        case (r_addr_cnt)
          2'd0:    w_col_nxt[7:0]  = nif.IO_in;
          2'd1:    w_col_nxt[15:8] = nif.IO_in;
          2'd2:    w_row_nxt       = nif.IO_in;
          default: ;
        endcase
        if (r_addr_cnt != 2'd3) w_addr_cnt_nxt = r_addr_cnt + 2'd1;
      end else if (!nif.CLE && !nif.ALE && !w_busy &&
                   (r_state == ST_PROG_ADDR || r_state == ST_PROG_DATA)) begin
        w_buf_we    = 1'b1;
        w_state_nxt = ST_PROG_DATA;
        w_col_nxt   = {{(16 - c_col_w){1'b0}}, w_col_inc};
      end
    end

    if (w_re_fall) begin
      case (r_state)
        ST_READ_OUT: begin
          w_io_out_nxt = w_mem_rd;
          w_col_nxt    = {{(16 - c_col_w){1'b0}}, w_col_inc};
        end
        ST_ID_OUT: begin
          w_io_out_nxt = (r_id_idx == 2'd0) ? ID0 : (r_id_idx == 2'd1) ? ID1 : 8'h00;
          if (r_id_idx != 2'd2) w_id_idx_nxt = r_id_idx + 2'd1;
        end
        ST_STATUS_OUT: w_io_out_nxt = w_status;
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state     <= ST_IDLE;
      r_saved     <= ST_IDLE;
      r_busy_kind <= BK_NONE;
      r_col       <= 16'd0;
      r_busy_cnt  <= 16'd0;
      r_row       <= 8'd0;
      r_io_out    <= 8'd0;
      r_addr_cnt  <= 2'd0;
      r_id_idx    <= 2'd0;
      r_fail      <= 1'b0;
      r_copy_on   <= 1'b0;
      r_copy_idx  <= '0;
      r_nwe_s1    <= 1'b1;
      r_nwe_s2    <= 1'b1;
      r_nwe_d     <= 1'b1;
      r_nre_s1    <= 1'b1;
      r_nre_s2    <= 1'b1;
      r_nre_d     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_saved     <= w_saved_nxt;
      r_busy_kind <= w_busy_kind_nxt;
      r_col       <= w_col_nxt;
      r_busy_cnt  <= w_busy_cnt_nxt;
      r_row       <= w_row_nxt;
      r_io_out    <= w_io_out_nxt;
      r_addr_cnt  <= w_addr_cnt_nxt;
      r_id_idx    <= w_id_idx_nxt;
      r_fail      <= w_fail_nxt;
      r_copy_on   <= w_copy_on_nxt;
      r_copy_idx  <= w_copy_idx_nxt;
      r_nwe_s1    <= nif.nWE;
      r_nwe_s2    <= r_nwe_s1;
      r_nwe_d     <= r_nwe_s2;
      r_nre_s1    <= nif.nRE;
      r_nre_s2    <= r_nre_s1;
      r_nre_d     <= r_nre_s2;
    end
  end

  // Storage keeps its contents across reset
  always_ff @(posedge PCLK) begin
    if (w_buf_fill) begin
      for (int i = 0; i < PAGE_BYTES; i++) r_buf[i] <= 8'hFF;
    end else if (w_buf_we) begin
      r_buf[w_col_idx] <= nif.IO_in;
    end
    if (w_mem_we) r_mem[{w_row_idx, r_copy_idx}] <= r_buf[r_copy_idx];
  end
endmodule
`default_nettype wire

// File: tb/tb_nand_target_emu.sv
`default_nettype none
// ============================================================================
// Module   : tb_nand_target_emu
// Purpose  : Directed + randomized bench for nand_target_emu with a page model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nand_target_emu;
  localparam int c_pb = 64;
  localparam int c_np = 16;

  logic PCLK    = 1'b0;
  logic PRESETN = 1'b0;
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   run_len = 0;
  int   last_run = 0;

  logic [7:0] ref_mem [c_np][c_pb];

  nand_target_emu_if bus();

  nand_target_emu dut (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .nif     (bus)
  );

  always #5 PCLK = ~PCLK;

  // Length of the most recent RnB-low stretch, in clock cycles
  always @(negedge PCLK) begin
    if (bus.RnB === 1'b0) run_len <= run_len + 1;
    else if (run_len != 0) begin
      last_run <= run_len;
      run_len  <= 0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] stat(input logic wp, input logic rdy, input logic fl);
    return {wp, rdy, 5'b0, fl};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic cle, input logic ale, input logic [7:0] d);
    @(negedge PCLK);
    bus.CLE = cle; bus.ALE = ale; bus.IO_in = d; bus.nWE = 1'b0;
    repeat (4) @(negedge PCLK);
    bus.nWE = 1'b1;
    repeat (5) @(negedge PCLK);
  endtask

  task automatic addr3(input int col, input int page);
    wr(1'b0, 1'b1, col[7:0]);
    wr(1'b0, 1'b1, col[15:8]);
    wr(1'b0, 1'b1, page[7:0]);
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (bus.RnB !== 1'b1 && k < 300) begin
      @(negedge PCLK);
      k++;
    end
    check(tag, bus.RnB, 1);
    @(negedge PCLK);
  endtask

  task automatic rd(input string tag, input logic [7:0] exp);
    @(negedge PCLK);
    bus.nRE = 1'b0;
    repeat (4) @(negedge PCLK);
    check({tag, "_oe"}, bus.IO_oe, 1);
    check(tag, bus.IO_out, exp);
    bus.nRE = 1'b1;
    repeat (4) @(negedge PCLK);
    check({tag, "_oe_off"}, bus.IO_oe, 0);
  endtask

  // Model: the page becomes all 0xFF except the bytes written (column wraps)
  task automatic prog(input int page, input int col, input logic [7:0] data[$], input logic wp);
    bus.nWP = wp;
    wr(1'b1, 1'b0, 8'h80);
    addr3(col, page);
    foreach (data[i]) wr(1'b0, 1'b0, data[i]);
    wr(1'b1, 1'b0, 8'h10);
    if (wp) begin
      for (int b = 0; b < c_pb; b++) ref_mem[page][b] = 8'hFF;
      foreach (data[i]) ref_mem[page][(col + i) % c_pb] = data[i];
    end
  endtask

  task automatic rd_setup(input int page, input int col);
    wr(1'b1, 1'b0, 8'h00);
    addr3(col, page);
    wr(1'b1, 1'b0, 8'h30);
    wait_ready("read_ready");
    check("read_busy_len", last_run, 8);
  endtask

  initial begin
    logic [7:0] q[$];
    int pg, cl, n, k;

    bus.nCE = 1'b0; bus.CLE = 1'b0; bus.ALE = 1'b0; bus.nWE = 1'b1;
    bus.nRE = 1'b1; bus.nWP = 1'b1; bus.IO_in = 8'h00;
    repeat (3) @(negedge PCLK);
    check("rst_rnb", bus.RnB, 1);
    check("rst_oe", bus.IO_oe, 0);
    check("rst_io_out", bus.IO_out, 0);
    PRESETN = 1'b1;
    repeat (2) @(negedge PCLK);

    // T1: Read ID
    wr(1'b1, 1'b0, 8'h90);
    rd("id0", 8'hEC);
    rd("id1", 8'hDA);
    rd("id_tail", 8'h00);

    // T2: program page 3, read it back
    q = '{8'h11, 8'h22, 8'h33};
    prog(3, 0, q, 1'b1);
    wait_ready("prog_ready");
    check("prog_busy_len", last_run, 80);
    rd_setup(3, 0);
    rd("p3_b0", ref_mem[3][0]);
    rd("p3_b1", ref_mem[3][1]);
    rd("p3_b2", ref_mem[3][2]);
    rd("p3_b3", 8'hFF);

    // T3: write-protected program fails and leaves the page alone
    q = '{8'h44, 8'h55, 8'h66};
    prog(3, 0, q, 1'b0);
    wait_ready("wp_ready");
    wr(1'b1, 1'b0, 8'h70);
    rd("wp_status", stat(1'b0, 1'b1, 1'b1));
    bus.nWP = 1'b1;
    rd_setup(3, 0);
    rd("wp_p3_b0", ref_mem[3][0]);
    rd("wp_p3_b1", ref_mem[3][1]);

    // T4: status while busy, 0x00 ignored while busy
    q.delete();
    cl = $urandom_range(0, c_pb - 1);
    n  = $urandom_range(1, 5);
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    prog(5, cl, q, 1'b1);
    wr(1'b1, 1'b0, 8'h70);
    bus.nWP = 1'b0;
    rd("busy_status_wp0", stat(1'b0, 1'b0, 1'b0));
    bus.nWP = 1'b1;
    rd("busy_status_wp1", stat(1'b1, 1'b0, 1'b0));
    wr(1'b1, 1'b0, 8'h00);
    rd("busy_status_after00", stat(1'b1, 1'b0, 1'b0));
    wait_ready("t4_ready");
    rd("ready_status", stat(1'b1, 1'b1, 1'b0));
    rd_setup(5, cl);
    for (int i = 0; i <= n; i++) rd("p5_rand", ref_mem[5][(cl + i) % c_pb]);

    // Randomized program/readback rounds
    for (int r = 0; r < 3; r++) begin
      q.delete();
      pg = $urandom_range(8, c_np - 1);
      cl = $urandom_range(0, c_pb - 1);
      n  = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
      prog(pg, cl, q, 1'b1);
      wait_ready("rnd_prog_ready");
      check("rnd_prog_busy_len", last_run, 80);
      rd_setup(pg, cl);
      for (int i = 0; i <= n; i++) rd("rnd_read", ref_mem[pg][(cl + i) % c_pb]);
    end

    // T5: reset command mid-program; busy = 2 sync + 1 decode + TBUSY_RST cycles
    q = '{8'hA5, 8'h5A};
    prog(6, 0, q, 1'b1);
    @(negedge PCLK);
    bus.CLE = 1'b1; bus.ALE = 1'b0; bus.IO_in = 8'hFF; bus.nWE = 1'b0;
    repeat (4) @(negedge PCLK);
    bus.nWE = 1'b1;
    k = 0;
    do begin
      @(posedge PCLK);
      #1;
      k++;
    end while (bus.RnB !== 1'b1 && k < 20);
    check("abort_rnb_edge", k, 7);
    @(negedge PCLK);
    bus.CLE = 1'b0;
    repeat (2) @(negedge PCLK);
    bus.nRE = 1'b0;
    repeat (4) @(negedge PCLK);
    check("abort_idle_oe", bus.IO_oe, 0);
    bus.nRE = 1'b1;
    repeat (4) @(negedge PCLK);
    wr(1'b1, 1'b0, 8'h70);
    rd("abort_status", stat(1'b1, 1'b1, 1'b0));

    // Reset during read busy, then during read output
    wr(1'b1, 1'b0, 8'h00);
    addr3(0, 3);
    wr(1'b1, 1'b0, 8'h30);
    check("readbusy_rnb", bus.RnB, 0);
    PRESETN = 1'b0;
    #1;
    check("rst_busy_rnb", bus.RnB, 1);
    @(negedge PCLK);
    PRESETN = 1'b1;
    rd_setup(3, 0);
    @(negedge PCLK);
    bus.nRE = 1'b0;
    repeat (4) @(negedge PCLK);
    check("pre_rst_oe", bus.IO_oe, 1);
    check("pre_rst_data", bus.IO_out, ref_mem[3][0]);
    PRESETN = 1'b0;
    #1;
    check("rst_read_rnb", bus.RnB, 1);
    check("rst_read_oe", bus.IO_oe, 0);
    check("rst_read_io", bus.IO_out, 0);
    @(negedge PCLK);
    bus.nRE = 1'b1;
    repeat (3) @(negedge PCLK);
    PRESETN = 1'b1;
    repeat (2) @(negedge PCLK);

    // T6: column wrap and nCE gating
    rd_setup(3, c_pb - 1);
    rd("wrap_last", ref_mem[3][c_pb - 1]);
    rd("wrap_first", ref_mem[3][0]);
    bus.nCE = 1'b1;
    @(negedge PCLK);
    bus.nRE = 1'b0;
    repeat (4) @(negedge PCLK);
    check("nce_oe", bus.IO_oe, 0);
    bus.nRE = 1'b1;
    repeat (4) @(negedge PCLK);
    wr(1'b1, 1'b0, 8'h90);
    bus.nCE = 1'b0;
    repeat (2) @(negedge PCLK);
    rd("nce_no_col_change", ref_mem[3][1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
